// File: rtl/cnt_arb_pkg.sv
// Shared types for the counter OBI arbiter: FSM states, master limit and the
// address-phase bundle that is muxed from the selected master to the slave.
package cnt_arb_pkg;

    localparam int MaxMst = 8;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RSP
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_ap_t;

endpackage

// File: rtl/cnt_obi_arbiter_if.sv
// Bus bundle around the arbiter: NumMst OBI master ports on one side and the
// counter's single OBI slave port on the other.
interface cnt_obi_arbiter_if #(
    parameter int NumMst = 2
);

    logic [NumMst-1:0]        mst_req_i;
    logic [NumMst-1:0]        mst_we_i;
    logic [NumMst-1:0][3:0]   mst_be_i;
    logic [NumMst-1:0][31:0]  mst_addr_i;
    logic [NumMst-1:0][31:0]  mst_wdata_i;
    logic [NumMst-1:0]        mst_gnt_o;
    logic [NumMst-1:0]        mst_rvalid_o;
    logic [31:0]              mst_rdata_o;

    logic                     slv_req_o;
    logic                     slv_we_o;
    logic [3:0]               slv_be_o;
    logic [31:0]              slv_addr_o;
    logic [31:0]              slv_wdata_o;
    logic                     slv_gnt_i;
    logic                     slv_rvalid_i;
    logic [31:0]              slv_rdata_i;

    // The arbiter itself: serves the masters, drives the counter slave.
    modport slave (
        input  mst_req_i, mst_we_i, mst_be_i, mst_addr_i, mst_wdata_i,
        output mst_gnt_o, mst_rvalid_o, mst_rdata_o,
        output slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o,
        input  slv_gnt_i, slv_rvalid_i, slv_rdata_i
    );

    // The surrounding system: requesting masters plus the counter slave.
    modport master (
        output mst_req_i, mst_we_i, mst_be_i, mst_addr_i, mst_wdata_i,
        input  mst_gnt_o, mst_rvalid_o, mst_rdata_o,
        input  slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o,
        output slv_gnt_i, slv_rvalid_i, slv_rdata_i
    );

endinterface

// File: rtl/cnt_rr_picker.sv
// Combinational round-robin search: first requester above ptr_i, otherwise
// wrap around to the lowest requester at or below ptr_i.
module cnt_rr_picker #(
    parameter  int NumMst = 2,
    localparam int IdxW   = $clog2(NumMst)
) (
    input  logic [NumMst-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              valid_o,
    output logic [IdxW-1:0]   idx_o
);

    logic            hi_found;
    logic [IdxW-1:0] hi_idx;
    logic [IdxW-1:0] lo_idx;

    // Scanning downwards leaves the lowest matching index in each half.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NumMst - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (i > int'(ptr_i)) begin
                    hi_found = 1'b1;
                    hi_idx   = IdxW'(i);
                end else begin
                    lo_idx   = IdxW'(i);
                end
            end
        end
    end

    assign valid_o = |req_i;
    assign idx_o   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/cnt_obi_arbiter.sv
// Round-robin arbiter sharing the counter's OBI slave among NumMst masters,
// one outstanding transaction at a time.
module cnt_obi_arbiter
    import cnt_arb_pkg::*;
#(
    parameter  int NumMst = 2,
    localparam int IdxW   = $clog2(NumMst)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    cnt_obi_arbiter_if.slave bus
);

    if (NumMst < 2 || NumMst > MaxMst) begin : g_bad_num_mst
        $error("cnt_obi_arbiter: NumMst must lie in 2..8");
    end

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] sel_q, sel_d;

    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;

    obi_ap_t           mst_ap [NumMst];
    obi_ap_t           slv_ap;
    logic              slv_req;
    logic [NumMst-1:0] gnt;
    logic [NumMst-1:0] rvalid;
    logic [31:0]       rdata;

    for (genvar gi = 0; gi < NumMst; gi++) begin : g_ap
        assign mst_ap[gi] = '{we:    bus.mst_we_i[gi],
                              be:    bus.mst_be_i[gi],
                              addr:  bus.mst_addr_i[gi],
                              wdata: bus.mst_wdata_i[gi]};
    end

    cnt_rr_picker #(
        .NumMst (NumMst)
    ) u_picker (
        .req_i   (bus.mst_req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= IdxW'(NumMst - 1);
            owner_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        sel_d   = sel_q;
        slv_req = 1'b0;
        slv_ap  = '0;
        gnt     = '0;
        rvalid  = '0;
        rdata   = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    slv_req = 1'b1;
                    slv_ap  = mst_ap[pick_idx];
                    if (bus.slv_gnt_i) begin
                        gnt[pick_idx] = 1'b1;
                        owner_d       = pick_idx;
                        ptr_d         = pick_idx;
                        state_d       = RSP;
                    end else begin
                        sel_d   = pick_idx;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Selection is frozen until granted; a withdrawn request aborts.
                if (!bus.mst_req_i[sel_q]) begin
                    state_d = IDLE;
                end else begin
                    slv_req = 1'b1;
                    slv_ap  = mst_ap[sel_q];
                    if (bus.slv_gnt_i) begin
                        gnt[sel_q] = 1'b1;
                        owner_d    = sel_q;
                        ptr_d      = sel_q;
                        state_d    = RSP;
                    end
                end
            end
            RSP: begin
                if (bus.slv_rvalid_i) begin
                    rvalid[owner_q] = 1'b1;
                    rdata           = bus.slv_rdata_i;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs drop the instant reset asserts, not at the next edge.
        if (rst_i) begin
            slv_req = 1'b0;
            slv_ap  = '0;
            gnt     = '0;
            rvalid  = '0;
            rdata   = '0;
        end
    end

    assign bus.slv_req_o    = slv_req;
    assign bus.slv_we_o     = slv_ap.we;
    assign bus.slv_be_o     = slv_ap.be;
    assign bus.slv_addr_o   = slv_ap.addr;
    assign bus.slv_wdata_o  = slv_ap.wdata;
    assign bus.mst_gnt_o    = gnt;
    assign bus.mst_rvalid_o = rvalid;
    assign bus.mst_rdata_o  = rdata;

`ifndef SYNTHESIS
    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.mst_gnt_o));

    a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.mst_rvalid_o));

    a_ap_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.slv_req_o && !bus.slv_gnt_i) |=>
        (!bus.slv_req_o ||
         $stable({bus.slv_we_o, bus.slv_be_o, bus.slv_addr_o, bus.slv_wdata_o})));

    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q != RSP && bus.slv_rvalid_i)
                $warning("cnt_obi_arbiter: stray slave response ignored");
            if (state_q == HOLD && !bus.mst_req_i[sel_q])
                $warning("cnt_obi_arbiter: request withdrawn before grant");
        end
    end
`endif

endmodule
